// File: rtl/qsys0_pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, waits for a stable lock, releases the
// downstream system reset, and retries or faults when lock cannot be achieved.
module qsys0_pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_ok,
  output logic       fault,
  output logic [7:0] relock_count,
  output logic [2:0] dbg_state,
  output logic [3:0] dbg_retry_cnt
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUNNING   = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;
  logic [7:0]       r_relock;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_lock_ok;
  logic             r_fault;

  logic             w_locked_s;
  logic [3:0]       w_retry_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [7:0]       w_relock_next;

  assign w_locked_s    = r_sync2;
  assign w_retry_next  = r_retry + 4'd1;
  assign w_cnt_next    = r_cnt + CNT_W'(1);
  assign w_relock_next = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;

  // pll_locked is asynchronous to refclk; only the second flop feeds the FSM.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= S_PLL_RESET;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_relock  <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_lock_ok <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_PLL_RESET: begin
          // force_relock is deliberately ignored so the pulse length is fixed.
          if (r_cnt == RST_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_WAIT_LOCK: begin
          if (force_relock) begin
            r_state   <= S_PLL_RESET;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
          end else if (w_locked_s) begin
            // This locked cycle is the first of the stable run.
            r_state <= S_STABILIZE;
            r_cnt   <= CNT_W'(1);
          end else if (r_cnt == TO_LAST) begin
            r_retry   <= w_retry_next;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (w_retry_next == RETRY_MAX) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_PLL_RESET;
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_STABILIZE: begin
          if (force_relock) begin
            r_state   <= S_PLL_RESET;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
          end else if (!w_locked_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt >= STAB_LAST) begin
            r_state   <= S_RUNNING;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_sys_rst <= 1'b0;
            r_lock_ok <= 1'b1;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_RUNNING: begin
          // Lock loss takes precedence so a coincident force_relock counts once.
          if (!w_locked_s || force_relock) begin
            r_state   <= S_PLL_RESET;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_lock_ok <= 1'b0;
            if (!w_locked_s) begin
              r_relock <= w_relock_next;
            end
          end
        end
        S_FAULT: begin
          if (force_relock) begin
            r_state <= S_PLL_RESET;
            r_cnt   <= '0;
            r_retry <= '0;
            r_fault <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_PLL_RESET;
          r_cnt     <= '0;
          r_pll_rst <= 1'b1;
          r_sys_rst <= 1'b1;
          r_lock_ok <= 1'b0;
          r_fault   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign lock_ok       = r_lock_ok;
  assign fault         = r_fault;
  assign relock_count  = r_relock;
  assign dbg_state     = r_state;
  assign dbg_retry_cnt = r_retry;

endmodule
